// File: rtl/adder_metrics_pkg.sv
// rtl/adder_metrics_pkg.sv - shared types, defaults and helpers for the adder error monitors
package adder_metrics_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_ACC_W = 48;
    // Wide enough for the result of any monitor variant up to 64-bit operands
    localparam int MAX_RES_W = 65;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [MAX_RES_W-1:0] abs_diff(
        input logic [MAX_RES_W-1:0] a,
        input logic [MAX_RES_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/adder_ed_calc.sv
// rtl/adder_ed_calc.sv - combinational exact sum and error distance of one adder sample
module adder_ed_calc
    import adder_metrics_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    input  logic [WIDTH:0]   approx,
    output logic [WIDTH:0]   exact,
    output logic [WIDTH:0]   ed
);

    // Carry out lands in the extra result bit, so the exact sum never wraps
    assign exact = {1'b0, add1} + {1'b0, add2};
    assign ed    = (WIDTH+1)'(abs_diff(MAX_RES_W'(exact), MAX_RES_W'(approx)));

endmodule

// File: rtl/adder_error_monitor32.sv
// rtl/adder_error_monitor32.sv - windowed error-distance statistics for a 32-bit approximate adder
module adder_error_monitor32
    import adder_metrics_pkg::*;
#(
    parameter int          WIDTH  = DEF_WIDTH,
    parameter logic [31:0] WINDOW = 32'd1024,
    parameter int          ACC_W  = DEF_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ed_valid_o,
    output logic [WIDTH:0]   ed_o,
    output logic [31:0]      sample_count_o,
    output logic [31:0]      err_count_o,
    output logic [WIDTH:0]   max_ed_o,
    output logic [ACC_W-1:0] sum_ed_o
);

    state_t state;
    state_t state_next;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_add1;
    logic [WIDTH-1:0] s1_add2;
    logic [WIDTH:0]   s1_approx;
    logic             ed_nz;

    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   ed;

    logic             start_ok;
    logic             accept;
    logic             last_accept;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_next;

    assign start_ok    = start_i && ((state == IDLE) || (state == DONE));
    assign accept      = (state == RUN) && valid_i;
    assign last_accept = accept && (sample_count_o == (WINDOW - 32'd1));

    assign busy_o = (state == RUN) || (state == DRAIN);
    assign done_o = (state == DONE);

    adder_ed_calc #(
        .WIDTH (WIDTH)
    ) u_ed_calc (
        .add1   (s1_add1),
        .add2   (s1_add2),
        .approx (s1_approx),
        .exact  (exact),
        .ed     (ed)
    );

    // One extra bit catches the carry; once set, the sum pins at all-ones
    assign sum_wide = {1'b0, sum_ed_o} + (ACC_W+1)'(ed_o);
    assign sum_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            // Stage 1 empty means stage 2 retires its last sample on this edge
            DRAIN:   if (!s1_valid) state_next = DONE;
            DONE:    if (start_i) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            s1_valid       <= 1'b0;
            s1_add1        <= '0;
            s1_add2        <= '0;
            s1_approx      <= '0;
            ed_valid_o     <= 1'b0;
            ed_o           <= '0;
            ed_nz          <= 1'b0;
            sample_count_o <= '0;
            err_count_o    <= '0;
            max_ed_o       <= '0;
            sum_ed_o       <= '0;
        end else begin
            state    <= state_next;
            s1_valid <= accept;
            if (accept) begin
                s1_add1   <= add1_i;
                s1_add2   <= add2_i;
                s1_approx <= approx_i;
            end

            ed_valid_o <= s1_valid;
            if (s1_valid) begin
                ed_o  <= ed;
                ed_nz <= (exact != s1_approx);
            end

            // Pipeline is always empty in IDLE/DONE, so a start never races an update
            if (start_ok) begin
                sample_count_o <= '0;
                err_count_o    <= '0;
                max_ed_o       <= '0;
                sum_ed_o       <= '0;
            end else begin
                if (accept) begin
                    sample_count_o <= sample_count_o + 32'd1;
                end
                if (ed_valid_o) begin
                    err_count_o <= err_count_o + {31'd0, ed_nz};
                    if (ed_o > max_ed_o) begin
                        max_ed_o <= ed_o;
                    end
                    sum_ed_o <= sum_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_error_monitor32.sv
// tb/tb_adder_error_monitor32.sv - scoreboard bench for adder_error_monitor32
module tb_adder_error_monitor32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        valid;
    logic        sel;
    logic [31:0] add1;
    logic [31:0] add2;
    logic [32:0] approx;

    logic        busy_a, done_a, edv_a, busy_b, done_b, edv_b;
    logic [32:0] ed_a, max_a, ed_b, max_b;
    logic [31:0] cnt_a, err_a, cnt_b, err_b;
    logic [47:0] sum_a;
    logic [32:0] sum_b;

    logic        obs_busy, obs_done, obs_edv;
    logic [32:0] obs_ed, obs_max;
    logic [31:0] obs_cnt, obs_err;
    logic [47:0] obs_sum;

    logic [32:0] exp_q[$];
    bit          m_run;
    int unsigned m_cnt;
    logic [63:0] m_err, m_max, m_sum;
    int          n_pass;
    int          n_total;

    always #5 clk = ~clk;

    adder_error_monitor32 #(.WIDTH(32), .WINDOW(32'd1), .ACC_W(48)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .valid_i(valid & ~sel),
        .add1_i(add1), .add2_i(add2), .approx_i(approx),
        .busy_o(busy_a), .done_o(done_a), .ed_valid_o(edv_a), .ed_o(ed_a),
        .sample_count_o(cnt_a), .err_count_o(err_a), .max_ed_o(max_a), .sum_ed_o(sum_a)
    );

    adder_error_monitor32 #(.WIDTH(32), .WINDOW(32'd4), .ACC_W(33)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start & sel), .valid_i(valid & sel),
        .add1_i(add1), .add2_i(add2), .approx_i(approx),
        .busy_o(busy_b), .done_o(done_b), .ed_valid_o(edv_b), .ed_o(ed_b),
        .sample_count_o(cnt_b), .err_count_o(err_b), .max_ed_o(max_b), .sum_ed_o(sum_b)
    );

    assign obs_busy = sel ? busy_b : busy_a;
    assign obs_done = sel ? done_b : done_a;
    assign obs_edv  = sel ? edv_b  : edv_a;
    assign obs_ed   = sel ? ed_b   : ed_a;
    assign obs_cnt  = sel ? cnt_b  : cnt_a;
    assign obs_err  = sel ? err_b  : err_a;
    assign obs_max  = sel ? max_b  : max_a;
    assign obs_sum  = sel ? {15'd0, sum_b} : sum_a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [32:0] model_ed(input logic [31:0] a, input logic [31:0] b,
                                             input logic [32:0] ap);
        logic [32:0] ex;
        ex = {1'b0, a} + {1'b0, b};
        return (ex >= ap) ? (ex - ap) : (ap - ex);
    endfunction

    function automatic int unsigned win();
        return sel ? 4 : 1;
    endfunction

    // Scoreboard: every emitted ED must match the oldest accepted sample
    always @(negedge clk) begin
        logic [32:0] e;
        logic [63:0] cap;
        if (!rst && obs_edv) begin
            if (exp_q.size() == 0) begin
                check("ed_unexpected", 64'(obs_edv), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("ed", 64'(obs_ed), 64'(e));
                cap = sel ? ((64'd1 << 33) - 1) : ((64'd1 << 48) - 1);
                m_err = m_err + ((e != 0) ? 64'd1 : 64'd0);
                if (64'(e) > m_max) m_max = 64'(e);
                m_sum = (m_sum + 64'(e) > cap) ? cap : m_sum + 64'(e);
            end
        end
    end

    task automatic sample(input logic [31:0] a, input logic [31:0] b, input logic [32:0] ap);
        add1 = a; add2 = b; approx = ap; valid = 1'b1; start = 1'b0;
        if (m_run) begin
            exp_q.push_back(model_ed(a, b, ap));
            m_cnt++;
            if (m_cnt == win()) m_run = 0;
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0; start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1; valid = 1'b0;
        if (!m_run) begin
            m_run = 1; m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!obs_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(obs_done), 64'd1);
        check("busy_at_done", 64'(obs_busy), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_cnt"}, 64'(obs_cnt), 64'(m_cnt));
        check({tag, "_err"}, 64'(obs_err), m_err);
        check({tag, "_max"}, 64'(obs_max), m_max);
        check({tag, "_sum"}, 64'(obs_sum), m_sum);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(obs_busy), 64'd0);
        check({tag, "_done"}, 64'(obs_done), 64'd0);
        check({tag, "_edv"}, 64'(obs_edv), 64'd0);
        check({tag, "_ed"}, 64'(obs_ed), 64'd0);
        check({tag, "_cnt"}, 64'(obs_cnt), 64'd0);
        check({tag, "_err"}, 64'(obs_err), 64'd0);
        check({tag, "_max"}, 64'(obs_max), 64'd0);
        check({tag, "_sum"}, 64'(obs_sum), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        logic [32:0] ex;
        n_pass = 0; n_total = 0;
        m_run = 0; m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
        sel = 1'b0; rst = 1'b1; start = 1'b0; valid = 1'b0;
        add1 = '0; add2 = '0; approx = '0;

        // Reset with random inputs toggling
        repeat (4) begin
            start = 1'($urandom); valid = 1'($urandom);
            add1 = $urandom; add2 = $urandom; approx = {1'($urandom), $urandom};
            @(negedge clk);
        end
        check_zero("rst_a");
        sel = 1'b1;
        check_zero("rst_b");
        sel = 1'b0;
        rst = 1'b0; start = 1'b0; valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        check("idle_valid_cnt", 64'(obs_cnt), 64'd0);
        check("idle_busy", 64'(obs_busy), 64'd0);

        // WINDOW=1 single sample
        do_start();
        check("run_busy", 64'(obs_busy), 64'd1);
        sample(32'h0000_00FF, 32'h0000_0001, 33'h0);
        check("single_cnt_lat1", 64'(obs_cnt), 64'd1);
        idle(1);
        check("single_edv", 64'(obs_edv), 64'd1);
        check("single_ed", 64'(obs_ed), 64'h100);
        check("single_not_done", 64'(obs_done), 64'd0);
        idle(1);
        check("single_done_3cyc", 64'(obs_done), 64'd1);
        check("single_err", 64'(obs_err), 64'd1);
        check("single_max", 64'(obs_max), 64'h100);
        check("single_sum", 64'(obs_sum), 64'h100);
        check_stats("single");

        // ED sign: approx above exact
        do_start();
        sample(32'h0000_0010, 32'h0, 33'h0_0000_0030);
        idle(1);
        check("sign_ed", 64'(obs_ed), 64'h20);
        wait_done();
        check_stats("sign");

        // WINDOW=4: six exact samples, last two must be ignored
        sel = 1'b1;
        do_start();
        sample(32'h5555_5555, 32'hAAAA_AAAA, 33'h0_FFFF_FFFF);
        check("win_cnt_lat1", 64'(obs_cnt), 64'd1);
        repeat (5) sample(32'h5555_5555, 32'hAAAA_AAAA, 33'h0_FFFF_FFFF);
        wait_done();
        idle(3);
        check("win_cnt", 64'(obs_cnt), 64'd4);
        check("win_err", 64'(obs_err), 64'd0);
        check("win_sum", 64'(obs_sum), 64'd0);
        check_stats("win");

        // Saturation with ACC_W=33
        do_start();
        sample(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0);
        sample(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0);
        idle(3);
        check("sat_after2", 64'(obs_sum), 64'h1_FFFF_FFFF);
        sample(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0);
        sample(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0);
        wait_done();
        check("sat_hold", 64'(obs_sum), 64'h1_FFFF_FFFF);
        check("sat_max", 64'(obs_max), 64'h1_FFFF_FFFE);
        check("sat_err", 64'(obs_err), 64'd4);
        check_stats("sat");

        // Start during RUN is ignored; reset kills the in-flight sample
        do_start();
        sample(32'd1, 32'd2, 33'd0);
        do_start();
        check("start_in_run_cnt", 64'(obs_cnt), 64'd1);
        check("start_in_run_busy", 64'(obs_busy), 64'd1);
        sample(32'd7, 32'd7, 33'd0);
        rst = 1'b1;
        exp_q.delete();
        m_run = 0; m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        idle(4);
        check_zero("midrst_after");

        // Fresh window from zero with random operands
        do_start();
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            ex = {1'b0, ra} + {1'b0, rb};
            if (i != 0) ex = ex ^ (33'd1 << (4 * i + 1));
            sample(ra, rb, ex);
        end
        wait_done();
        check("fresh_cnt", 64'(obs_cnt), 64'd4);
        check("fresh_err", 64'(obs_err), 64'd3);
        check_stats("fresh");
        idle(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
